// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C register-transaction sequencer.
package i2c_seq_pkg;

  // Status codes reported by i2c_master on m_status.
  typedef enum logic [3:0] {
    MsBusy    = 4'd0,
    MsAck     = 4'd1,
    MsNack    = 4'd2,
    MsRdata   = 4'd3,
    MsStopped = 4'd4
  } m_status_e;

  // Completion codes returned on rsp_err.
  typedef enum logic [1:0] {
    ErrOk      = 2'b00,
    ErrNack    = 2'b01,
    ErrTimeout = 2'b10
  } rsp_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StAddrW,
    StReg,
    StWdata,
    StAddrR,
    StRead,
    StStop,
    StResp
  } state_e;

  // R/W bit appended to the 7-bit device address.
  localparam logic DevWrite = 1'b0;
  localparam logic DevRead  = 1'b1;

  localparam int unsigned CntWidth = 21;

  // Master status that lets a step complete successfully.
  function automatic m_status_e expected_status(state_e st);
    case (st)
      StAddrW, StReg, StWdata, StAddrR: return MsAck;
      StRead:                           return MsRdata;
      StStop:                           return MsStopped;
      default:                          return MsBusy;
    endcase
  endfunction

  // Successor of a bus step that completed normally.
  function automatic state_e next_step(state_e st, logic is_read);
    case (st)
      StAddrW: return StReg;
      StReg:   return is_read ? StAddrR : StWdata;
      StWdata: return StStop;
      StAddrR: return StRead;
      StRead:  return StStop;
      default: return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Two-port round-robin arbiter; a tie goes to the port not granted last.
module i2c_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_q;  // port favoured on a tie

  // One-hot grant, only while enabled.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Favour the other port after every accepted grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Arbitrates two register requesters and sequences each request into i2c_master strobes.
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned STROBE_GUARD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_dev,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic [7:0]  m_data,
  output logic        m_start,
  output logic        m_rw,
  output logic        m_stop,
  input  logic [7:0]  m_rdata,
  input  logic [3:0]  m_status
);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q;
  logic                  owner_q, rw_q;
  logic [6:0]            dev_q;
  logic [7:0]            reg_q, wdata_q;
  logic [7:0]            rdata_q, rdata_d;
  rsp_err_e              err_q, err_d;
  logic [1:0]            rsp_err_q;
  logic [7:0]            rsp_rdata_q;
  logic [1:0]            grant;
  logic                  in_idle, first, guard_done, timed_out;

  assign in_idle    = (state_q == StIdle);
  assign first      = (cnt_q == '0);
  assign guard_done = (cnt_q > CntWidth'(STROBE_GUARD));
  assign timed_out  = (cnt_q >= CntWidth'(TIMEOUT_CYCLES - 1));

  i2c_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (in_idle),
    .update (in_idle),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign busy      = !in_idle;
  assign rsp_valid = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign m_start   = first && (state_q == StAddrW || state_q == StAddrR);
  assign m_rw      = first && (state_q == StReg || state_q == StWdata || state_q == StRead);
  assign m_stop    = first && (state_q == StStop);

  // Byte presented to the master, stable for the whole step.
  always_comb begin
    m_data = 8'h00;
    case (state_q)
      StAddrW: m_data = {dev_q, DevWrite};
      StReg:   m_data = reg_q;
      StWdata: m_data = wdata_q;
      StAddrR: m_data = {dev_q, DevRead};
      default: m_data = 8'h00;
    endcase
  end

  // Step sequencing, error recording and read-data capture.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          state_d = StAddrW;
          err_d   = ErrOk;
          rdata_d = 8'h00;
        end
      end
      StAddrW, StReg, StWdata, StAddrR, StRead: begin
        if (guard_done && m_status == expected_status(state_q)) begin
          state_d = next_step(state_q, rw_q);
          if (state_q == StRead) rdata_d = m_rdata;
        end else if (guard_done && m_status == MsNack) begin
          if (err_q == ErrOk) err_d = ErrNack;
          state_d = StStop;
        end else if (timed_out) begin
          if (err_q == ErrOk) err_d = ErrTimeout;
          state_d = StStop;
        end
      end
      StStop: begin
        if (guard_done && m_status == MsStopped) begin
          state_d = StResp;
        end else if (timed_out) begin
          if (err_q == ErrOk) err_d = ErrTimeout;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state, error and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      err_q   <= ErrOk;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Per-step cycle counter: cleared on every state change, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (cnt_q != {CntWidth{1'b1}}) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  // Capture the winning request's fields at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else if (in_idle && grant != 2'b00) begin
      owner_q <= grant[1];
      rw_q    <= req_rw[grant[1]];
      dev_q   <= grant[1] ? req_dev[13:7] : req_dev[6:0];
      reg_q   <= grant[1] ? req_reg[15:8] : req_reg[7:0];
      wdata_q <= grant[1] ? req_wdata[15:8] : req_wdata[7:0];
    end
  end

  // Response code and data, held from RESP until the next RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q   <= 2'b00;
      rsp_rdata_q <= 8'h00;
    end else if (state_d == StResp && state_q != StResp) begin
      rsp_err_q   <= err_d;
      rsp_rdata_q <= (err_d == ErrOk) ? rdata_d : 8'h00;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed self-checking bench for i2c_txn_sequencer with a behavioural i2c_master responder.
module tb_i2c_txn_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_rw;
  logic [13:0] req_dev;
  logic [15:0] req_reg, req_wdata;
  logic [1:0]  rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata, m_data, m_rdata;
  logic        busy, m_start, m_rw, m_stop;
  logic [3:0]  m_status = 4'd0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  i2c_txn_sequencer #(
    .TIMEOUT_CYCLES (50),
    .STROBE_GUARD   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_dev   (req_dev),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .m_data    (m_data),
    .m_start   (m_start),
    .m_rw      (m_rw),
    .m_stop    (m_stop),
    .m_rdata   (m_rdata),
    .m_status  (m_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Master model: mode 0 ACKs everything, 1 NACKs the register byte, 2 stays BUSY.
  int          mode = 0;
  logic        rd_addr = 1'b0;
  int          rw_idx = 0;
  logic [9:0]  ev_q[$];  // {kind, byte}: 1 start, 2 rw, 3 stop
  int          ev_cyc[$];

  always @(negedge clk) begin
    if (m_start) begin
      ev_q.push_back({2'd1, m_data});
      ev_cyc.push_back(cyc);
      rd_addr  <= m_data[0];
      rw_idx   <= 0;
      m_status <= (mode == 2) ? 4'd0 : 4'd1;
    end else if (m_rw) begin
      ev_q.push_back({2'd2, m_data});
      ev_cyc.push_back(cyc);
      if (mode == 2)                    m_status <= 4'd0;
      else if (rd_addr)                 m_status <= 4'd3;
      else if (mode == 1 && rw_idx == 0) m_status <= 4'd2;
      else                              m_status <= 4'd1;
      rw_idx <= rw_idx + 1;
    end else if (m_stop) begin
      ev_q.push_back({2'd3, m_data});
      ev_cyc.push_back(cyc);
      m_status <= (mode == 2) ? 4'd0 : 4'd4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int port, input logic rw, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd, output int gcyc);
    logic found;
    found = 1'b0;
    gcyc  = -1;
    @(posedge clk); #1;
    req_rw[port]           = rw;
    req_dev[port*7 +: 7]   = dev;
    req_reg[port*8 +: 8]   = rg;
    req_wdata[port*8 +: 8] = wd;
    req_valid[port]        = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[port]) begin
        found = 1'b1;
        gcyc  = cyc;
        break;
      end
    end
    check("grant_seen", {31'b0, found}, 32'd1);
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [1:0] rv, output logic [1:0] er, output logic [7:0] rd,
                          output int rc);
    rv = 2'b00; er = 2'b00; rd = 8'h00; rc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        rv = rsp_valid; er = rsp_err; rd = rsp_rdata; rc = cyc;
        break;
      end
    end
  endtask

  initial begin
    int         g, rc, base, starts, nrsp;
    logic [1:0] rv, er;
    logic [7:0] rd;
    logic [1:0] gr[3];
    int         gc[3];
    logic       found;

    reset = 1'b1;
    req_valid = 2'b00; req_rw = 2'b00; req_dev = '0; req_reg = '0; req_wdata = '0;
    m_rdata = 8'h3C;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, busy, m_data, m_start, m_rw,
                          m_stop}, 32'd0);

    // Port 0 write, dev 0x48 reg 0x01 data 0xA5.
    base = ev_q.size();
    issue(0, 1'b0, 7'h48, 8'h01, 8'hA5, g);
    wait_rsp(rv, er, rd, rc);
    check("wr_rsp_valid", rv, 2'b01);
    check("wr_rsp_err", er, 2'b00);
    check("wr_rsp_rdata", rd, 8'h00);
    check("wr_latency", rc - g, 32'd17);
    check("wr_ev_count", ev_q.size() - base, 32'd4);
    check("wr_ev0", ev_q[base], {2'd1, 8'h90});
    check("wr_ev1", ev_q[base+1], {2'd2, 8'h01});
    check("wr_ev2", ev_q[base+2], {2'd2, 8'hA5});
    check("wr_ev3_kind", ev_q[base+3][9:8], 2'd3);
    @(negedge clk);
    check("wr_busy_after", busy, 1'b0);

    // Port 1 read, dev 0x50 reg 0x10, master returns 0x3C.
    base = ev_q.size();
    issue(1, 1'b1, 7'h50, 8'h10, 8'h00, g);
    wait_rsp(rv, er, rd, rc);
    check("rd_rsp_valid", rv, 2'b10);
    check("rd_rsp_err", er, 2'b00);
    check("rd_rsp_rdata", rd, 8'h3C);
    check("rd_latency", rc - g, 32'd21);
    check("rd_ev_count", ev_q.size() - base, 32'd5);
    check("rd_ev0", ev_q[base], {2'd1, 8'hA0});
    check("rd_ev1", ev_q[base+1], {2'd2, 8'h10});
    check("rd_ev2", ev_q[base+2], {2'd1, 8'hA1});
    check("rd_ev3_kind", ev_q[base+3][9:8], 2'd2);
    check("rd_ev4_kind", ev_q[base+4][9:8], 2'd3);
    check("rd_rdata_held", rsp_rdata, 8'h3C);

    // Both ports valid for three consecutive grants: 0, 1, 0.
    @(posedge clk); #1;
    req_rw = 2'b00; req_dev = {7'h49, 7'h48}; req_reg = 16'h0302; req_wdata = 16'h5AC3;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      gr[k] = 2'b00; gc[k] = -1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          gr[k] = req_ready; gc[k] = cyc;
          break;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(rv, er, rd, rc);
    check("arb_grant0", gr[0], 2'b01);
    check("arb_grant1", gr[1], 2'b10);
    check("arb_grant2", gr[2], 2'b01);
    check("arb_gap01", gc[1] - gc[0], 32'd18);
    check("arb_gap12", gc[2] - gc[1], 32'd18);
    check("arb_last_rsp", rv, 2'b01);

    // NACK on the register byte of a read: no repeated start, no read strobe.
    mode = 1;
    base = ev_q.size();
    issue(1, 1'b1, 7'h50, 8'h22, 8'h00, g);
    wait_rsp(rv, er, rd, rc);
    check("nack_rsp_valid", rv, 2'b10);
    check("nack_rsp_err", er, 2'b01);
    check("nack_rsp_rdata", rd, 8'h00);
    check("nack_latency", rc - g, 32'd13);
    check("nack_ev_count", ev_q.size() - base, 32'd3);
    check("nack_ev0", ev_q[base], {2'd1, 8'hA0});
    check("nack_ev1", ev_q[base+1], {2'd2, 8'h22});
    check("nack_ev2_kind", ev_q[base+2][9:8], 2'd3);
    mode = 0;

    // Master stuck BUSY with a 50-cycle step timeout.
    mode = 2;
    base = ev_q.size();
    issue(0, 1'b0, 7'h48, 8'h01, 8'hA5, g);
    wait_rsp(rv, er, rd, rc);
    check("to_rsp_valid", rv, 2'b01);
    check("to_rsp_err", er, 2'b10);
    check("to_ev_count", ev_q.size() - base, 32'd2);
    check("to_ev1_kind", ev_q[base+1][9:8], 2'd3);
    check("to_stop_delay", ev_cyc[base+1] - ev_cyc[base], 32'd50);
    check("to_latency", rc - g, 32'd101);
    @(negedge clk);
    check("to_busy_after", busy, 1'b0);
    mode = 0;

    // Reset pulsed during the read-data step of a port 0 read.
    issue(0, 1'b1, 7'h50, 8'h10, 8'h00, g);
    starts = 0;
    found  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_start) starts++;
      if (starts == 2 && m_rw) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reached_read", {31'b0, found}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_async_outputs", {req_ready, rsp_valid, busy, m_data, m_start, m_rw, m_stop},
          32'd0);
    check("rst_async_rsp", {rsp_err, rsp_rdata}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) nrsp++;
    end
    check("rst_no_rsp", nrsp, 32'd0);
    @(posedge clk); #1;
    req_rw = 2'b00;
    req_valid = 2'b11;
    gr[0] = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        gr[0] = req_ready;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("rst_ptr_port0", gr[0], 2'b01);
    wait_rsp(rv, er, rd, rc);
    check("rst_after_rsp", {rv, er}, {2'b01, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
